// File: rtl/fetch_aligner.sv
// Fetch aligner: word reads into a halfword queue, one aligned 16/32-bit instruction per handshake; rsp cycle M -> InstValid M+1.
// Backpressure: decode stalls via InstReady; fetch holds MemReqValid low while fewer than two queue slots are free.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemReqAddr,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] InstOut,
  output logic [31:0] InstAddr,
  output logic        InstCompressed
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int QW = 16 * QDEPTH;

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} stateT;

  stateT         state, stateNext;
  logic [QW-1:0] qData, qShift, pushVec, pushMask, qNext;
  logic [CW-1:0] count, countNext, base;
  logic [31:0]   fetchAddr;
  logic          skipLow;
  logic [15:0]   hw0, hw1;
  logic          isComp, reqFire, pop, outstanding;
  logic [1:0]    popN, pushN;

  assign MemReqAddr = fetchAddr;

  always_comb begin
    hw0            = qData[15:0];
    hw1            = qData[31:16];
    isComp         = hw0[1:0] != 2'b11;
    InstValid      = (count != '0 && isComp) || (count >= CW'(2));
    InstCompressed = isComp;
    InstOut        = isComp ? {16'h0000, hw0} : {hw1, hw0};
    reqFire        = MemReqValid && MemReqReady;
    pop            = InstValid && InstReady && !Redirect;
    popN           = !pop ? 2'd0 : (isComp ? 2'd1 : 2'd2);
    pushN          = (state == WAIT && MemRspValid && !Redirect) ? (skipLow ? 2'd1 : 2'd2) : 2'd0;

    // Queue is a shift register: head at bit 0, new halfwords land right after the survivors.
    base     = count - CW'(popN);
    qShift   = qData >> {popN, 4'b0000};
    pushVec  = QW'(skipLow ? {16'h0000, MemRspData[31:16]} : MemRspData) << {base, 4'b0000};
    pushMask = QW'(skipLow ? 32'h0000_ffff : 32'hffff_ffff) << {base, 4'b0000};
    if (pushN == 2'd0) begin
      pushVec  = '0;
      pushMask = '0;
    end
    qNext     = (qShift & ~pushMask) | pushVec;
    countNext = base + CW'(pushN);

    stateNext   = state;
    outstanding = 1'b0;
    case (state)
      FETCH: begin
        if (reqFire) stateNext = WAIT;
        outstanding = reqFire;
      end
      WAIT: begin
        if (MemRspValid) stateNext = FETCH;
        outstanding = !MemRspValid;
      end
      DRAIN: begin
        if (MemRspValid) stateNext = FETCH;
        outstanding = !MemRspValid;
      end
      default: stateNext = FETCH;
    endcase

    // A request still in flight must have its response swallowed before refetching.
    if (Redirect) begin
      stateNext = outstanding ? DRAIN : FETCH;
      countNext = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      qData       <= '0;
      count       <= '0;
      fetchAddr   <= RESET_PC & ~32'd3;
      skipLow     <= RESET_PC[1];
      InstAddr    <= RESET_PC & ~32'd1;
      MemReqValid <= 1'b0;
    end else begin
      state       <= stateNext;
      qData       <= qNext;
      count       <= countNext;
      MemReqValid <= (stateNext == FETCH) && (countNext <= CW'(QDEPTH - 2));
      if (Redirect) begin
        fetchAddr <= RedirectAddr & ~32'd3;
        skipLow   <= RedirectAddr[1];
        InstAddr  <= RedirectAddr & ~32'd1;
      end else begin
        if (reqFire) fetchAddr <= fetchAddr + 32'd4;
        if (pushN != 2'd0) skipLow <= 1'b0;
        if (pop) InstAddr <= InstAddr + (isComp ? 32'd2 : 32'd4);
      end
    end
  end
endmodule
